qam16_hard_slicer: RTL

- Upstream datapath stage of the hard-decision QAM demapper: slices each synchronized 16-QAM I/Q sample pair to a 4-bit Gray-coded symbol.
- Packs two symbols per byte and writes the bytes into the demapper FIFO.
- The FIFO write side is gated by the demapper controller's `write_enable` and by the FIFO's `wfull` flag.
- Keeps accepted-symbol and dropped-data counters for host diagnostics.

---
 rtl/qam16_hard_slicer.sv | 63 ++++++
 1 files changed

// File: rtl/qam16_hard_slicer.sv
// qam16_hard_slicer: slices 16-QAM I/Q samples to Gray nibbles, packs byte pairs into the demapper FIFO
module qam16_hard_slicer #(
  parameter int IQ_W   = 8,
  parameter int THRESH = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   dclk,
  input  logic                   reset,
  input  logic                   sym_valid,
  input  logic signed [IQ_W-1:0] i_in,
  input  logic signed [IQ_W-1:0] q_in,
  input  logic                   write_enable,
  input  logic                   wfull,
  output logic [7:0]             wdata,
  output logic                   wreq,
  output logic [CNT_W-1:0]       sym_count,
  output logic [CNT_W-1:0]       drop_count
);
  localparam logic signed [IQ_W:0] TH  = (IQ_W+1)'(THRESH);
  localparam logic signed [IQ_W:0] NTH = -TH;
  function automatic logic [1:0] slice(input logic signed [IQ_W:0] x);
    return (x >= TH) ? 2'b10 : !x[IQ_W] ? 2'b11 : (x >= NTH) ? 2'b01 : 2'b00;
  endfunction
  logic signed [IQ_W:0] w_ix, w_qx;
  logic [3:0]           w_nib, r_nib, r_high;
  logic                 r_s1_valid, r_half, w_accept, w_write, w_drop;
  assign w_ix     = {i_in[IQ_W-1], i_in};
  assign w_qx     = {q_in[IQ_W-1], q_in};
  assign w_nib    = {slice(w_ix), slice(w_qx)};
  assign w_accept = sym_valid & write_enable;
  assign w_write  = r_s1_valid & r_half & !wfull;
  assign w_drop   = r_half & (r_s1_valid ? wfull : !write_enable);
  // stage 1: accept and slice a symbol while the controller is in receive mode
  always_ff @(posedge dclk or negedge reset)
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_nib      <= '0;
      sym_count  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_nib     <= w_nib;
        sym_count <= sym_count + CNT_W'(1);
      end
    end
  // stage 2: pair nibbles into bytes; a partial byte is abandoned when receive mode ends
  always_ff @(posedge dclk or negedge reset)
    if (!reset) begin
      r_half <= 1'b0;
      r_high <= '0;
      wdata  <= '0;
      wreq   <= 1'b0;
    end else begin
      wreq   <= w_write;
      r_half <= r_s1_valid ? !r_half : r_half & write_enable;
      if (r_s1_valid & !r_half) r_high <= r_nib;
      if (w_write) wdata <= {r_high, r_nib};
    end
  // saturating count of bytes lost to a full FIFO or to end of receive mode
  always_ff @(posedge dclk or negedge reset)
    if (!reset) drop_count <= '0;
    else if (w_drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
endmodule
